// File: rtl/chnl_rx_stream_pkg.sv
// Shared constants for the RIFFA channel receive path: word/length widths,
// FSM encodings and the per-beat word-count helper.
package chnl_rx_stream_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned LenW  = 32;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAck    = 2'd1;
  localparam logic [1:0] StData   = 2'd2;
  localparam logic [1:0] StWaitLo = 2'd3;

  // Words consumed by one accepted beat: min(rem, lanes), full 32-bit compare.
  function automatic logic [LenW-1:0] beat_words(input logic [LenW-1:0] rem,
                                                 input logic [LenW-1:0] lanes);
    return (rem < lanes) ? rem : lanes;
  endfunction

endpackage

// File: rtl/chnl_fifo2.sv
// Two-entry in-order valid/ready FIFO; head reads as zero when empty.
module chnl_fifo2 #(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic         empty_o,
  output logic [1:0]   cnt_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign cnt_o   = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/chnl_rx_stream.sv
// RIFFA CHNL_RX receive side: acks a host transfer, counts down its length and
// turns the data beats into a valid/ready stream through a 2-entry FIFO.
module chnl_rx_stream
  import chnl_rx_stream_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            chnl_rx_i,
  output logic            chnl_rx_ack_o,
  input  logic            chnl_rx_last_i,
  input  logic [LenW-1:0] chnl_rx_len_i,
  input  logic [DW-1:0]   chnl_rx_data_i,
  input  logic            chnl_rx_data_valid_i,
  output logic            chnl_rx_data_ren_o,
  output logic            out_val_o,
  output logic [DW-1:0]   out_data_o,
  input  logic            out_rdy_i,
  output logic            last_o,
  output logic            busy_o,
  output logic            trunc_o
);

  localparam int unsigned     LANES  = DW / WordW;
  localparam logic [LenW-1:0] LanesW = LenW'(LANES);

  logic [1:0]      state_q, state_d;
  logic [LenW-1:0] rem_q, rem_d;
  logic            last_q, last_d;
  logic            push;
  logic            trunc;
  logic            beat;
  logic [DW-1:0]   push_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      fifo_cnt;

  // Ready depends on the registered FIFO count only, never on a same-cycle pop.
  assign chnl_rx_data_ren_o = (state_q == StData) && !fifo_full;
  assign beat               = chnl_rx_data_valid_i && chnl_rx_data_ren_o;

  // Lanes at or beyond the remaining word count are zeroed (partial final beat).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [LenW-1:0] LaneIdx = LenW'(i);
    assign push_data[i*WordW +: WordW] =
        (LaneIdx < rem_q) ? chnl_rx_data_i[i*WordW +: WordW] : '0;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    last_d  = last_q;
    push    = 1'b0;
    trunc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (chnl_rx_i) begin
          rem_d   = chnl_rx_len_i;
          last_d  = chnl_rx_last_i;
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = (rem_q == '0) ? StWaitLo : StData;
      end
      StData: begin
        if (!chnl_rx_i && (rem_q != '0)) begin
          trunc   = 1'b1;
          rem_d   = '0;
          state_d = StIdle;
        end else if (beat) begin
          push  = 1'b1;
          rem_d = rem_q - beat_words(rem_q, LanesW);
          if (rem_d == '0) begin
            state_d = StWaitLo;
          end
        end
      end
      StWaitLo: begin
        if (!chnl_rx_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
    end
  end

  chnl_fifo2 #(
    .W (DW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .full_o  (fifo_full),
    .pop_i   (out_rdy_i),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt),
    .head_o  (out_data_o)
  );

  assign chnl_rx_ack_o = (state_q == StAck);
  assign out_val_o     = !fifo_empty;
  assign last_o        = last_q;
  assign busy_o        = (state_q != StIdle) || (fifo_cnt != 2'd0);
  assign trunc_o       = trunc;

endmodule
